// File: rtl/wbm_req_pkg.sv
// Shared types and constants for the Wishbone request engine.
package wbm_req_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    localparam logic [DAT_W-1:0] ERR_DATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_e;

endpackage

// File: rtl/wbm_req_timeout.sv
// Bus-cycle watchdog: counts stalled cycles and flags the cycle in which the limit is reached.
module wbm_req_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    // Expiry is flagged while the last allowed cycle is in progress so the bus drops right after it.
    localparam logic [15:0] LIMIT_C = 16'(TIMEOUT_CYCLES - 32'd1);

    logic [15:0] count_r;

    // Expiry decode.
    always_comb begin
        expired = enable & (count_r == LIMIT_C);
    end

    // Stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 16'd0;
        end else if (clear) begin
            count_r <= 16'd0;
        end else if (enable) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/wbm_req_engine.sv
// Single-outstanding request to Wishbone classic initiator with a valid/ready response channel.
// Optional bus watchdog enabled by defining WBM_REQ_TIMEOUT_EN.
module wbm_req_engine
    import wbm_req_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,

    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADR_W-1:0]  req_adr_i,
    input  logic [DAT_W-1:0]  req_dat_i,
    input  logic [SEL_W-1:0]  req_sel_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DAT_W-1:0]  rsp_dat_o,
    output logic              rsp_err_o,

    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [SEL_W-1:0]  wbm_sel_o,
    output logic [ADR_W-1:0]  wbm_adr_o,
    output logic [DAT_W-1:0]  wbm_dat_o,
    input  logic [DAT_W-1:0]  wbm_dat_i,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i
);

    if ((TIMEOUT_CYCLES < 32'd1) || (TIMEOUT_CYCLES > 32'd65535)) begin : g_bad_timeout
        $error("wbm_req_engine: TIMEOUT_CYCLES out of range 1..65535");
    end

    wbm_state_e         state_r;
    wbm_state_e         state_nx_s;

    logic               req_ready_r;
    logic               rsp_valid_r;
    logic [DAT_W-1:0]   rsp_dat_r;
    logic               rsp_err_r;
    logic               cyc_r;
    logic               stb_r;
    logic               we_r;
    logic [SEL_W-1:0]   sel_r;
    logic [ADR_W-1:0]   adr_r;
    logic [DAT_W-1:0]   dat_r;

    logic               accept_s;
    logic               bus_done_s;
    logic               bus_err_s;
    logic               rsp_fire_s;
    logic               timeout_s;

`ifdef WBM_REQ_TIMEOUT_EN
    logic               tmo_en_s;
    logic               tmo_clr_s;

    // Watchdog runs only while the bus is stalled; any other state parks it at zero.
    always_comb begin
        tmo_en_s  = (state_r == BUS) & ~wbm_ack_i & ~wbm_err_i;
        tmo_clr_s = (state_r != BUS);
    end

    wbm_req_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .enable  (tmo_en_s),
        .clear   (tmo_clr_s),
        .expired (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Handshake and termination decode.
    always_comb begin
        accept_s   = req_valid_i & req_ready_r;
        bus_done_s = (state_r == BUS) & (wbm_ack_i | wbm_err_i | timeout_s);
        bus_err_s  = wbm_err_i | timeout_s;
        rsp_fire_s = rsp_valid_r & rsp_ready_i;
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = BUS;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BUS: begin
                if (bus_done_s) begin
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = BUS;
                end
            end
            RESP: begin
                if (rsp_fire_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Registered bus and response outputs; ready follows the next state so the RESP exit cycle stays closed.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_dat_r   <= {DAT_W{1'b0}};
            rsp_err_r   <= 1'b0;
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            we_r        <= 1'b0;
            sel_r       <= {SEL_W{1'b0}};
            adr_r       <= {ADR_W{1'b0}};
            dat_r       <= {DAT_W{1'b0}};
        end else begin
            req_ready_r <= (state_nx_s == IDLE);
            if (accept_s) begin
                we_r  <= req_we_i;
                sel_r <= req_sel_i;
                adr_r <= req_adr_i;
                dat_r <= req_dat_i;
                cyc_r <= 1'b1;
                stb_r <= 1'b1;
            end else if (bus_done_s) begin
                cyc_r       <= 1'b0;
                stb_r       <= 1'b0;
                rsp_valid_r <= 1'b1;
                rsp_err_r   <= bus_err_s;
                if (bus_err_s) begin
                    rsp_dat_r <= ERR_DATA;
                end else if (we_r) begin
                    rsp_dat_r <= {DAT_W{1'b0}};
                end else begin
                    rsp_dat_r <= wbm_dat_i;
                end
            end else if (rsp_fire_s) begin
                rsp_valid_r <= 1'b0;
            end else begin
                rsp_valid_r <= rsp_valid_r;
            end
        end
    end

    assign req_ready_o = req_ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_dat_o   = rsp_dat_r;
    assign rsp_err_o   = rsp_err_r;
    assign wbm_cyc_o   = cyc_r;
    assign wbm_stb_o   = stb_r;
    assign wbm_we_o    = we_r;
    assign wbm_sel_o   = sel_r;
    assign wbm_adr_o   = adr_r;
    assign wbm_dat_o   = dat_r;

endmodule

// File: tb/tb_wbm_req_engine.sv
// Directed bench for wbm_req_engine; the timeout scenario is built when WBM_REQ_TIMEOUT_EN is defined.
module tb_wbm_req_engine;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic [3:0]  req_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack;
    logic        err;

    int vecs;
    int fails;

    wbm_req_engine #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_adr_i   (req_adr),
        .req_dat_i   (req_dat),
        .req_sel_i   (req_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_sel_o   (sel),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (dat_o),
        .wbm_dat_i   (dat_i),
        .wbm_ack_i   (ack),
        .wbm_err_i   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request and let it be accepted on the next edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1;
        req_we    = w;
        req_adr   = a;
        req_dat   = d;
        req_sel   = s;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        vecs++;
        if ({cyc, stb, rsp_valid, rsp_err, we, req_ready} !== 6'b000000) begin
            $display("FAIL reset_ctrl: got %b need 000000", {cyc, stb, rsp_valid, rsp_err, we, req_ready});
            fails++;
        end
        vecs++;
        if ({adr, dat_o, sel, rsp_dat} !== 100'd0) begin
            $display("FAIL reset_data: adr=%h dat=%h sel=%h rsp=%h need all 0", adr, dat_o, sel, rsp_dat);
            fails++;
        end
        tick();
        vecs++;
        if (req_ready !== 1'b0) begin
            $display("FAIL reset_ready_held: got %b need 0", req_ready);
            fails++;
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        vecs++;
        if (req_ready !== 1'b1) begin
            $display("FAIL reset_ready_after: got %b need 1", req_ready);
            fails++;
        end
    endtask

    task automatic test_write();
        int ncyc;
        rsp_ready = 1'b0;
        issue(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
        vecs++;
        if ({we, adr, dat_o, sel} !== {1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF}) begin
            $display("FAIL write_payload: we=%b adr=%h dat=%h sel=%h", we, adr, dat_o, sel);
            fails++;
        end
        ncyc = 0;
        for (int i = 0; i < 10 && cyc === 1'b1; i++) begin
            ncyc++;
            if (stb !== 1'b1 || adr !== 32'h3000_0004 || dat_o !== 32'hA5A5_1234) begin
                $display("FAIL write_hold: stb=%b adr=%h dat=%h at bus cycle %0d", stb, adr, dat_o, ncyc);
                fails++;
            end
            ack = (ncyc == 3);
            tick();
        end
        ack = 1'b0;
        vecs++;
        if (ncyc !== 3) begin
            $display("FAIL write_cyc_len: got %0d cycles need 3", ncyc);
            fails++;
        end
        vecs++;
        if ({rsp_valid, rsp_err, rsp_dat, stb, req_ready} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            $display("FAIL write_rsp: valid=%b err=%b dat=%h stb=%b ready=%b need 1 0 0 0 0", rsp_valid, rsp_err, rsp_dat, stb, req_ready);
            fails++;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vecs++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            $display("FAIL write_drain: valid=%b ready=%b need 0 1", rsp_valid, req_ready);
            fails++;
        end
    endtask

    task automatic test_read();
        rsp_ready = 1'b0;
        issue(1'b0, 32'h3000_0000, 32'h1111_2222, 4'h3);
        vecs++;
        if ({cyc, stb, we, dat_o, sel} !== {1'b1, 1'b1, 1'b0, 32'h1111_2222, 4'h3}) begin
            $display("FAIL read_bus: cyc=%b stb=%b we=%b dat=%h sel=%h", cyc, stb, we, dat_o, sel);
            fails++;
        end
        dat_i = 32'hCAFE_F00D;
        ack   = 1'b1;
        tick();
        ack   = 1'b0;
        dat_i = 32'h0BAD_0BAD;
        vecs++;
        if ({cyc, rsp_valid, rsp_err, rsp_dat} !== {1'b0, 1'b1, 1'b0, 32'hCAFE_F00D}) begin
            $display("FAIL read_rsp: cyc=%b valid=%b err=%b dat=%h need 0 1 0 cafef00d", cyc, rsp_valid, rsp_err, rsp_dat);
            fails++;
        end
        // A stray ack in RESP must not disturb the held response.
        ack = 1'b1;
        err = 1'b1;
        tick();
        ack = 1'b0;
        err = 1'b0;
        vecs++;
        if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
            $display("FAIL read_rsp_hold: valid=%b err=%b dat=%h", rsp_valid, rsp_err, rsp_dat);
            fails++;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_ack_err();
        issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
        dat_i = 32'hDEAD_BEEF;
        ack   = 1'b1;
        err   = 1'b1;
        tick();
        ack = 1'b0;
        err = 1'b0;
        vecs++;
        if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b1, 32'h0}) begin
            $display("FAIL ack_err: valid=%b err=%b dat=%h need 1 1 0", rsp_valid, rsp_err, rsp_dat);
            fails++;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        issue(1'b1, 32'h3000_000C, 32'h7777_8888, 4'h1);
        err = 1'b1;
        tick();
        err = 1'b0;
        vecs++;
        if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b1, 32'h0}) begin
            $display("FAIL err_only: valid=%b err=%b dat=%h need 1 1 0", rsp_valid, rsp_err, rsp_dat);
            fails++;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_rsp_stall();
        int bad;
        issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        dat_i = 32'h5A5A_0F0F;
        ack   = 1'b1;
        tick();
        ack   = 1'b0;
        dat_i = 32'h0;
        req_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if ({rsp_valid, rsp_err, rsp_dat, req_ready, cyc} !== {1'b1, 1'b0, 32'h5A5A_0F0F, 1'b0, 1'b0}) begin
                bad++;
            end
            tick();
        end
        vecs++;
        if (bad !== 0) begin
            $display("FAIL rsp_stall: %0d unstable cycles need 0", bad);
            fails++;
        end
        rsp_ready = 1'b1;
        vecs++;
        if ({rsp_valid, req_ready} !== 2'b10) begin
            $display("FAIL rsp_stall_c6: valid=%b ready=%b need 1 0", rsp_valid, req_ready);
            fails++;
        end
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        vecs++;
        if ({rsp_valid, req_ready, cyc} !== 3'b010) begin
            $display("FAIL rsp_stall_done: valid=%b ready=%b cyc=%b need 0 1 0", rsp_valid, req_ready, cyc);
            fails++;
        end
    endtask

    task automatic test_idle_ignore();
        ack = 1'b1;
        err = 1'b1;
        tick();
        tick();
        ack = 1'b0;
        err = 1'b0;
        vecs++;
        if ({rsp_valid, rsp_err, cyc, req_ready} !== 4'b0001) begin
            $display("FAIL idle_ignore: valid=%b err=%b cyc=%b ready=%b need 0 0 0 1", rsp_valid, rsp_err, cyc, req_ready);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] cyc_h;
        logic [7:0] val_h;
        logic [7:0] rdy_h;
        int         n;
        cyc_h = 8'h00;
        val_h = 8'h00;
        rdy_h = 8'h00;
        n = 0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_adr   = 32'h3000_0020;
        dat_i     = 32'h0000_1234;
        for (int t = 0; t < 8; t++) begin
            tick();
            cyc_h[t] = cyc;
            val_h[t] = rsp_valid;
            rdy_h[t] = req_ready;
            if (cyc === 1'b1) n++;
            if (n == 3) req_valid = 1'b0;
            ack = cyc;
        end
        ack = 1'b0;
        tick();
        rsp_ready = 1'b0;
        vecs++;
        if (cyc_h !== 8'b0100_1001) begin
            $display("FAIL b2b_cyc: got %b need 01001001", cyc_h);
            fails++;
        end
        vecs++;
        if (val_h !== 8'b1001_0010) begin
            $display("FAIL b2b_valid: got %b need 10010010", val_h);
            fails++;
        end
        vecs++;
        if (rdy_h !== 8'b0010_0100) begin
            $display("FAIL b2b_ready: got %b need 00100100", rdy_h);
            fails++;
        end
    endtask

    task automatic test_reset_mid_bus();
        int bad;
        issue(1'b0, 32'h3000_0030, 32'h0, 4'hF);
`ifndef WBM_REQ_TIMEOUT_EN
        for (int i = 0; i < 20; i++) tick();
        vecs++;
        if ({cyc, stb, rsp_valid} !== 3'b110) begin
            $display("FAIL no_timeout_wait: cyc=%b stb=%b valid=%b need 1 1 0", cyc, stb, rsp_valid);
            fails++;
        end
`endif
        tick();
        #2;
        rst = 1'b1;
        #1;
        vecs++;
        if ({cyc, stb, rsp_valid, req_ready, adr} !== {4'b0000, 32'h0}) begin
            $display("FAIL rst_mid_bus: cyc=%b stb=%b valid=%b ready=%b adr=%h need all 0", cyc, stb, rsp_valid, req_ready, adr);
            fails++;
        end
        ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ack = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid !== 1'b0 || cyc !== 1'b0) bad++;
            tick();
        end
        vecs++;
        if ({req_ready, bad[3:0]} !== {1'b1, 4'd0}) begin
            $display("FAIL rst_mid_bus_after: ready=%b spurious=%0d need 1 0", req_ready, bad);
            fails++;
        end
    endtask

`ifdef WBM_REQ_TIMEOUT_EN
    task automatic test_timeout();
        int ncyc;
        issue(1'b0, 32'h3000_0040, 32'h0, 4'hF);
        ncyc = 0;
        for (int i = 0; i < 30 && cyc === 1'b1; i++) begin
            ncyc++;
            tick();
        end
        vecs++;
        if (ncyc !== 8) begin
            $display("FAIL timeout_len: got %0d bus cycles need 8", ncyc);
            fails++;
        end
        vecs++;
        if ({cyc, rsp_valid, rsp_err, rsp_dat} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
            $display("FAIL timeout_rsp: cyc=%b valid=%b err=%b dat=%h need 0 1 1 0", cyc, rsp_valid, rsp_err, rsp_dat);
            fails++;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        // Counter must restart from zero for the next transaction.
        issue(1'b0, 32'h3000_0044, 32'h0, 4'hF);
        ncyc = 0;
        for (int i = 0; i < 30 && cyc === 1'b1; i++) begin
            ncyc++;
            tick();
        end
        vecs++;
        if (ncyc !== 8) begin
            $display("FAIL timeout_restart: got %0d bus cycles need 8", ncyc);
            fails++;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        vecs      = 0;
        fails     = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_adr   = 32'h0;
        req_dat   = 32'h0;
        req_sel   = 4'h0;
        rsp_ready = 1'b0;
        dat_i     = 32'h0;
        ack       = 1'b0;
        err       = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_ack_err();
        test_rsp_stall();
        test_idle_ignore();
        test_back_to_back();
        test_reset_mid_bus();
`ifdef WBM_REQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/wbm_req_engine.md
WBM_REQ_ENGINE -- requirements
Module: wbm_req_engine

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max bus cycles waiting for ack/err (range 1..65535).
REQ-002 SHALL have port wb_clk_i  input  1  the single clock; all logic rising-edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports req_valid_i in 1, req_ready_o out 1  request handshake.
REQ-005 SHALL have ports req_we_i in 1, req_adr_i in 32, req_dat_i in 32, req_sel_i in 4  request payload.
REQ-006 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1, rsp_dat_o out 32, rsp_err_o out 1  response channel.
REQ-007 SHALL have Wishbone classic initiator ports wbm_cyc_o, wbm_stb_o, wbm_we_o out 1; wbm_sel_o out 4; wbm_adr_o, wbm_dat_o out 32; wbm_dat_i in 32; wbm_ack_i, wbm_err_i in 1.

Function
REQ-008 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE, one outstanding transaction.
REQ-009 req_ready_o SHALL be 1 only in IDLE; request accepted on req_valid_i & req_ready_o edge.
REQ-010 On acceptance SHALL register payload and enter BUS; wbm_cyc_o=wbm_stb_o=1 from next cycle (1-cycle latency).
REQ-011 In BUS, wbm_we_o/sel/adr/dat SHALL hold registered values stable until termination.
REQ-012 wbm_ack_i or wbm_err_i sampled high in BUS SHALL drop cyc/stb next cycle and enter RESP.
REQ-013 On ack: rsp_dat_o = wbm_dat_i captured at ack edge (reads), 32'h0 for writes; rsp_err_o=0.
REQ-014 On err, or ack and err same cycle: rsp_err_o=1, rsp_dat_o=32'h0 (err wins).
REQ-015 In RESP rsp_valid_o SHALL be 1 and hold payload stable until rsp_valid_o & rsp_ready_i, then IDLE.
REQ-016 A new request SHALL NOT be accepted in the RESP->IDLE transition cycle (back-to-back min period 3 cycles with zero-wait slave and rsp_ready_i=1).
REQ-017 ack/err outside BUS SHALL be ignored.
REQ-018 wbm_dat_o SHALL be driven with registered data for reads too (don't-care to slave).

Reset
REQ-019 On wb_rst_i assertion, immediately (asynchronously): state=IDLE, wbm_cyc_o=wbm_stb_o=0, rsp_valid_o=0, rsp_err_o=0, all data/address/sel outputs 0, wbm_we_o=0, timeout counter 0.
REQ-020 req_ready_o SHALL be 0 while wb_rst_i high, 1 first cycle after deassertion.
REQ-021 Reset mid-BUS SHALL abort the cycle with no response generated.

Configuration
REQ-022 Macro WBM_REQ_TIMEOUT_EN: when defined, counter increments each BUS cycle without ack/err; reaching TIMEOUT_CYCLES SHALL terminate as error (rsp_err_o=1, rsp_dat_o=32'h0), counter clears on leaving BUS.
REQ-023 When WBM_REQ_TIMEOUT_EN undefined, no counter logic; BUS waits indefinitely; TIMEOUT_CYCLES unused.

Structure
REQ-024 Package wbm_req_pkg SHALL hold FSM state enum (IDLE, BUS, RESP), ADR_W=32, DAT_W=32, SEL_W=4, ERR_DATA=32'h0.
REQ-025 Timeout SHALL be sub-module wbm_req_timeout (enable, clear, expired), instantiated only under WBM_REQ_TIMEOUT_EN.

Verification
REQ-026 Write adr 0x3000_0004 dat 0xA5A5_1234 sel 0xF, ack after 2 wait cycles -> cyc/stb high 3 cycles, rsp_valid with err=0, dat=0.
REQ-027 Read adr 0x3000_0000, slave returns 0xCAFE_F00D with ack -> rsp_dat_o=0xCAFE_F00D next cycle.
REQ-028 Slave asserts ack and err same cycle -> rsp_err_o=1, rsp_dat_o=0.
REQ-029 rsp_ready_i held 0 for 5 cycles -> rsp_valid/payload stable, req_ready_o=0 throughout; accepted cycle 6.
REQ-030 With WBM_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave silent -> cyc drops after 8 BUS cycles, rsp_err_o=1.
REQ-031 wb_rst_i asserted mid-BUS -> cyc/stb 0 same cycle, no rsp_valid, req_ready_o=1 after deassertion.
